// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - shared state encoding, 7-segment glyphs and password nibble helper
package controle_pkg;

  typedef enum logic [2:0] {
    ENTRADA   = 3'd0,
    ABERTO    = 3'd1,
    ERRO      = 3'd2,
    BLOQUEADO = 3'd3,
    PROGRAMA  = 3'd4
  } estado_t;

  // Segment order gfedcba, active-high
  localparam logic [6:0] SEG_DIGITO [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SEG_A       = 7'b1110111;
  localparam logic [6:0] SEG_E       = 7'b1111001;
  localparam logic [6:0] SEG_B       = 7'b1111100;
  localparam logic [6:0] SEG_P       = 7'b1110011;
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;

  localparam int SENHA_MAX_W = 64;

  // First digit sits in the most significant nibble
  function automatic logic [3:0] digito_senha(input logic [SENHA_MAX_W-1:0] senha,
                                              input int n_digitos,
                                              input int idx);
    return 4'(senha >> (4 * (n_digitos - 1 - idx)));
  endfunction

endpackage

// File: rtl/decod_7seg.sv
// rtl/decod_7seg.sv - combinational decimal digit to 7-segment decoder, blank above 9
module decod_7seg
  import controle_pkg::*;
(
  input  logic [3:0] i_digito,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_APAGADO;
    if (i_digito <= 4'd9) o_seg = SEG_DIGITO[i_digito];
  end

endmodule

// File: rtl/controle_acesso.sv
// rtl/controle_acesso.sv - digit-entry lock sequencer with programmable password and timed lockout
module controle_acesso
  import controle_pkg::*;
#(
  parameter int                     N_DIGITOS     = 5,
  parameter int                     MAX_ERROS     = 3,
  parameter int                     T_BLOQUEIO    = 50,
  parameter logic [4*N_DIGITOS-1:0] SENHA_INICIAL = 20'h59060,
  localparam int IW = $clog2(N_DIGITOS + 1),
  localparam int EW = $clog2(MAX_ERROS + 1),
  localparam int TW = (T_BLOQUEIO > 1) ? $clog2(T_BLOQUEIO) : 1
)(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [3:0]    i_numero,
  input  logic          i_insere,
  input  logic          i_programa,
  output logic          o_ledErro,
  output logic          o_ledAberto,
  output logic [EW-1:0] o_tentativas,
  output logic [6:0]    o_display
);

  estado_t                r_estado, w_estado_n;
  logic [IW-1:0]          r_idx, w_idx_n;
  logic [EW-1:0]          r_erros, w_erros_n;
  logic                   r_falha, w_falha_n;
  logic [TW-1:0]          r_timer, w_timer_n;
  logic                   r_insere_d;
  logic [4*N_DIGITOS-1:0] r_senha, w_senha_n;
  logic [4*N_DIGITOS-1:0] r_nova, w_nova_n, w_nova_ins;

  logic       w_ev, w_ultimo, w_erro_digito, w_ultimo_erro;
  logic [3:0] w_digito_senha, w_idx_digito;
  logic [6:0] w_seg_idx;

  assign w_ev           = i_insere & ~r_insere_d;
  assign w_ultimo       = (r_idx == IW'(N_DIGITOS - 1));
  assign w_digito_senha = digito_senha(64'(r_senha), N_DIGITOS, int'(r_idx));
  assign w_erro_digito  = (i_numero != w_digito_senha) || (i_numero > 4'd9);
  assign w_ultimo_erro  = (r_erros == EW'(MAX_ERROS - 1));
  assign w_idx_digito   = 4'(r_idx);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_estado <= ENTRADA;
    else          r_estado <= w_estado_n;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idx      <= '0;
      r_erros    <= '0;
      r_falha    <= 1'b0;
      r_timer    <= '0;
      r_insere_d <= 1'b0;
      r_senha    <= SENHA_INICIAL;
      r_nova     <= '0;
    end else begin
      r_idx      <= w_idx_n;
      r_erros    <= w_erros_n;
      r_falha    <= w_falha_n;
      r_timer    <= w_timer_n;
      r_insere_d <= i_insere;
      r_senha    <= w_senha_n;
      r_nova     <= w_nova_n;
    end
  end

  // Shadow copy with the digit at the current position replaced
  always_comb begin
    w_nova_ins = r_nova;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (r_idx == IW'(i)) w_nova_ins[4*(N_DIGITOS-1-i) +: 4] = i_numero;
    end
  end

  always_comb begin
    w_estado_n = r_estado;
    w_idx_n    = r_idx;
    w_erros_n  = r_erros;
    w_falha_n  = r_falha;
    w_timer_n  = r_timer;
    w_senha_n  = r_senha;
    w_nova_n   = r_nova;
    case (r_estado)
      ENTRADA: begin
        if (w_ev) begin
          if (w_ultimo) begin
            w_idx_n   = '0;
            w_falha_n = 1'b0;
            if (!(r_falha || w_erro_digito)) begin
              w_estado_n = ABERTO;
              w_erros_n  = '0;
            end else if (w_ultimo_erro) begin
              w_estado_n = BLOQUEADO;
              w_timer_n  = TW'(T_BLOQUEIO - 1);
              w_erros_n  = EW'(MAX_ERROS);
            end else begin
              w_estado_n = ERRO;
              w_erros_n  = r_erros + EW'(1);
            end
          end else begin
            w_idx_n   = r_idx + IW'(1);
            w_falha_n = r_falha | w_erro_digito;
          end
        end
      end
      ERRO: begin
        if (w_ev) w_estado_n = ENTRADA;
      end
      ABERTO: begin
        if (w_ev) begin
          w_idx_n    = '0;
          w_estado_n = i_programa ? PROGRAMA : ENTRADA;
        end
      end
      PROGRAMA: begin
        if (w_ev) begin
          if (i_numero > 4'd9) begin
            w_estado_n = ABERTO;
            w_idx_n    = '0;
          end else begin
            w_nova_n = w_nova_ins;
            if (w_ultimo) begin
              w_senha_n  = w_nova_ins;
              w_estado_n = ENTRADA;
              w_idx_n    = '0;
            end else begin
              w_idx_n = r_idx + IW'(1);
            end
          end
        end
      end
      BLOQUEADO: begin
        if (r_timer == '0) begin
          w_estado_n = ENTRADA;
          w_erros_n  = '0;
          w_idx_n    = '0;
        end else begin
          w_timer_n = r_timer - TW'(1);
        end
      end
      default: w_estado_n = ENTRADA;
    endcase
  end

  decod_7seg u_decod_idx (
    .i_digito (w_idx_digito),
    .o_seg    (w_seg_idx)
  );

  assign o_ledErro    = (r_estado == ERRO) || (r_estado == BLOQUEADO);
  assign o_ledAberto  = (r_estado == ABERTO);
  assign o_tentativas = EW'(MAX_ERROS) - r_erros;

  always_comb begin
    o_display = SEG_APAGADO;
    case (r_estado)
      ENTRADA:   o_display = w_seg_idx;
      ABERTO:    o_display = SEG_A;
      ERRO:      o_display = SEG_E;
      BLOQUEADO: o_display = SEG_B;
      PROGRAMA:  o_display = SEG_P;
      default:   o_display = SEG_APAGADO;
    endcase
  end

endmodule

// File: tb/tb_controle_acesso.sv
// tb/tb_controle_acesso.sv - directed self-checking bench for controle_acesso
module tb_controle_acesso;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] numero   = 4'd0;
  logic       insere   = 1'b0;
  logic       programa = 1'b0;
  logic       led_erro, led_aberto;
  logic [1:0] tent;
  logic [6:0] disp;
  logic [10:0] obs, exp_v;
  int total = 0;
  int bad   = 0;

  assign obs = {led_erro, led_aberto, tent, disp};

  always #5 clk = ~clk;

  controle_acesso dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_numero     (numero),
    .i_insere     (insere),
    .i_programa   (programa),
    .o_ledErro    (led_erro),
    .o_ledAberto  (led_aberto),
    .o_tentativas (tent),
    .o_display    (disp)
  );

  // Outputs are observed at the falling edge where the button is released
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    numero = d;
    insere = 1'b1;
    @(negedge clk);
    insere = 1'b0;
  endtask

  task automatic enter5(input logic [19:0] seq);
    for (int i = 0; i < 5; i++) press(seq[19-4*i -: 4]);
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    insere   = 1'b0;
    programa = 1'b0;
    numero   = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_held got=%b want=%b", obs, exp_v); end
    rst_n = 1'b1;
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_released got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_abre;
    do_reset;
    enter5(20'h59060);
    exp_v = {1'b0, 1'b1, 2'd3, 7'b1110111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL abre got=%b want=%b", obs, exp_v); end
    press(4'd3);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL relock got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_erro;
    logic [6:0]  glyph [0:4];
    logic [19:0] seq;
    glyph = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    seq   = 20'h59360;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      press(seq[19-4*i -: 4]);
      exp_v = {1'b0, 1'b0, 2'd3, glyph[i+1]}; total++;
      if (obs !== exp_v) begin bad++; $display("FAIL erro_progress%0d got=%b want=%b", i, obs, exp_v); end
    end
    press(seq[3:0]);
    exp_v = {1'b1, 1'b0, 2'd2, 7'b1111001}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL erro_final got=%b want=%b", obs, exp_v); end
    press(4'd9);
    exp_v = {1'b0, 1'b0, 2'd2, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL erro_ack got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_bloqueio;
    do_reset;
    for (int s = 0; s < 3; s++) begin
      enter5(20'h11111);
      if (s < 2) begin
        exp_v = {1'b1, 1'b0, 2'(2 - s), 7'b1111001}; total++;
        if (obs !== exp_v) begin bad++; $display("FAIL wrong_seq%0d got=%b want=%b", s, obs, exp_v); end
        press(4'd0);
      end
    end
    exp_v = {1'b1, 1'b0, 2'd0, 7'b1111100}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lock_enter got=%b want=%b", obs, exp_v); end
    for (int i = 0; i < 5; i++) press(4'd5);
    exp_v = {1'b1, 1'b0, 2'd0, 7'b1111100}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lock_ignore got=%b want=%b", obs, exp_v); end
    repeat (35) @(negedge clk);
    numero = 4'd5;
    insere = 1'b1;
    repeat (4) @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'd0, 7'b1111100}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lock_edge49 got=%b want=%b", obs, exp_v); end
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lock_edge50 got=%b want=%b", obs, exp_v); end
    repeat (3) @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lock_held_noev got=%b want=%b", obs, exp_v); end
    insere = 1'b0;
    press(4'd5);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0000110}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL lock_repress got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_hold;
    do_reset;
    @(negedge clk);
    numero = 4'd5;
    insere = 1'b1;
    repeat (20) @(negedge clk);
    insere = 1'b0;
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0000110}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hold_once got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_programa;
    do_reset;
    enter5(20'h59060);
    programa = 1'b1;
    press(4'd0);
    programa = 1'b0;
    exp_v = {1'b0, 1'b0, 2'd3, 7'b1110011}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog_enter got=%b want=%b", obs, exp_v); end
    enter5(20'h12345);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog_commit got=%b want=%b", obs, exp_v); end
    enter5(20'h59060);
    exp_v = {1'b1, 1'b0, 2'd2, 7'b1111001}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog_old_rejected got=%b want=%b", obs, exp_v); end
    press(4'd0);
    enter5(20'h12345);
    exp_v = {1'b0, 1'b1, 2'd3, 7'b1110111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog_new_accepted got=%b want=%b", obs, exp_v); end
    programa = 1'b1;
    press(4'd0);
    programa = 1'b0;
    press(4'd7);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b1110011}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog2_digit got=%b want=%b", obs, exp_v); end
    press(4'd12);
    exp_v = {1'b0, 1'b1, 2'd3, 7'b1110111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog2_abort got=%b want=%b", obs, exp_v); end
    press(4'd0);
    enter5(20'h12345);
    exp_v = {1'b0, 1'b1, 2'd3, 7'b1110111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL prog2_unchanged got=%b want=%b", obs, exp_v); end
  endtask

  task automatic test_reset_async;
    do_reset;
    enter5(20'h59060);
    programa = 1'b1;
    press(4'd0);
    programa = 1'b0;
    enter5(20'h12345);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b1001111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mid_entry got=%b want=%b", obs, exp_v); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_rst_entry got=%b want=%b", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    enter5(20'h59060);
    exp_v = {1'b0, 1'b1, 2'd3, 7'b1110111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL senha_restored got=%b want=%b", obs, exp_v); end
    press(4'd0);
    for (int s = 0; s < 3; s++) begin
      enter5(20'h22222);
      if (s < 2) press(4'd0);
    end
    repeat (10) @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'd0, 7'b1111100}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mid_lock got=%b want=%b", obs, exp_v); end
    #3 rst_n = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_rst_lock got=%b want=%b", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_v = {1'b0, 1'b0, 2'd3, 7'b0111111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL after_lock_rst got=%b want=%b", obs, exp_v); end
    enter5(20'h59060);
    exp_v = {1'b0, 1'b1, 2'd3, 7'b1110111}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL unlock_after_rst got=%b want=%b", obs, exp_v); end
  endtask

  initial begin
    test_reset;
    test_abre;
    test_erro;
    test_bloqueio;
    test_hold;
    test_programa;
    test_reset_async;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_acesso.md
# controle_acesso

Access-sequencing controller for the digit-entry lock. Accepts 4-bit digits on a `insere` strobe and checks them against a programmable N-digit password. Counts failed attempts, enforces a timed lockout after repeated failures, and lets an unlocked user reprogram the password. Drives the error/open LEDs and the 7-segment status display, replacing the fixed-password sequence checker at the top of the lock design.

## Interface
- `N_DIGITOS`, 5: password length in digits.
- `MAX_ERROS`, 3: failed attempts that trigger lockout (≥1).
- `T_BLOQUEIO`, 50: lockout duration in clk cycles (≥1).
- `SENHA_INICIAL`, 20'h59060: reset password, 4 bits per digit, first digit in MS nibble (width 4·N_DIGITOS).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `numero` in 4: digit to enter, valid 0–9.
- `insere` in 1: level from button; a digit is taken on its rising edge only.
- `programa` in 1: password-change request, sampled only in ABERTO.
- `ledErro` out 1: high in ERRO and BLOQUEADO.
- `ledAberto` out 1: high in ABERTO.
- `tentativas` out clog2(MAX_ERROS+1): remaining attempts, MAX_ERROS − erros.
- `display` out 7: segments gfedcba, active-high.

## Operation
- Edge detect: `insere_d` registers `insere` every cycle, in all states. Accept condition `ev = insere & ~insere_d`. A held button yields exactly one event.
- States: ENTRADA, ABERTO, ERRO, BLOQUEADO, PROGRAMA.
- ENTRADA:
  - Each `ev` compares `numero` to `senha[idx]`, increments `idx`, and ORs any mismatch or `numero` > 9 into `falha`.
  - Entry always continues to N digits, so the failing position is not revealed.
  - On the N-th `ev`, `idx`←0 and `falha`←0, then:
    - no failure → ABERTO, `erros`←0;
    - failure and erros+1 = MAX_ERROS → BLOQUEADO, `timer`←T_BLOQUEIO−1, `erros`←MAX_ERROS;
    - otherwise → ERRO, `erros`+1.
- ERRO: next `ev` is consumed as acknowledge (digit discarded) → ENTRADA.
- ABERTO: `ev` with `programa`=1 → PROGRAMA, `idx`←0. `ev` with `programa`=0 → ENTRADA (relock).
- PROGRAMA:
  - Each `ev` with `numero` ≤ 9 writes the shadow register `nova[idx]`.
  - `numero` > 9 aborts → ABERTO; `senha` unchanged, `idx`←0.
  - On the N-th valid digit, `senha`←`nova` in one cycle (atomic) → ENTRADA.
- BLOQUEADO:
  - `timer` decrements every cycle; `ev` is ignored.
  - When `timer`=0 → ENTRADA with `erros`←0 and `idx`←0.
- Display:
  - ENTRADA shows `idx` as a decimal glyph.
  - ABERTO 'A' = 1110111, ERRO 'E' = 1111001, BLOQUEADO 'b' = 1111100, PROGRAMA 'P' = 1110011.
- Widths: `idx` clog2(N_DIGITOS+1); `timer` clog2(T_BLOQUEIO).

## Timing
- Reset values: state ENTRADA, `idx`=0, `erros`=0, `falha`=0, `timer`=0, `insere_d`=0, `senha`=SENHA_INICIAL, `nova`=0.
- Output reset values: `ledErro`=0, `ledAberto`=0, `tentativas`=MAX_ERROS, `display`=0111111.
- Outputs are a Moore decode of registered state. They change right after the edge that accepts an `ev`, i.e. the first edge where `insere` is sampled high after a low: latency 1 cycle.
- Lockout: entered on edge k; ENTRADA is visible after edge k+T_BLOQUEIO.
- If `insere` is still held high when BLOQUEADO ends, no `ev` fires until it is released and pressed again.
- `reset` asserted mid-entry, mid-program or mid-lockout returns everything to reset values immediately. A programmed password is lost.
- `numero` is don't-care except in cycles where `ev`=1.

## Structure
- Package `controle_pkg`:
  - state encoding (3-bit enum);
  - 7-segment constants for 0–9 and A/E/b/P;
  - helper function for `senha` nibble select.
- Sub-module `decod_7seg`: combinational 4-bit-to-segment decoder for digits 0–9, instantiated for the ENTRADA progress display.

## Test plan
- Reset, then enter 5,9,0,6,0 (one `ev` each) → ABERTO, `ledAberto`=1, `display`=1110111, `tentativas`=3.
- Enter 5,9,3,6,0 → ERRO only after the 5th digit; `display` shows 0–4 during entry, then 'E'; `tentativas`=2. Next `ev` → ENTRADA with `display`=0111111.
- Three wrong sequences → BLOQUEADO, `ledErro`=1. Presses during lockout are ignored. After exactly 50 cycles → ENTRADA with `tentativas`=3.
- Hold `insere` high for 20 cycles with `numero`=5 → `idx` advances exactly once to 1.
- Unlock, then `programa`=1 with `ev`, enter 1,2,3,4,5 → ENTRADA. Then 5,9,0,6,0 → ERRO, and 1,2,3,4,5 → ABERTO. In a second PROGRAMA, enter 7 then 12 → abort to ABERTO with the password unchanged.
- Assert `reset` after 3 digits, and separately mid-lockout → all outputs return to reset values asynchronously; `senha` returns to 59060.
